// File: rtl/selector_reader.sv
// ---------------------------------------------------------------------------
// selector_reader
//   Reads one 32-bit word from an external 256x32 serial data selector.
//   A transaction shifts an 8-bit channel address out (MSB first), pulses the
//   latch line, then clocks 32 data bits back in (MSB first) and presents the
//   word on dataOut with a one-cycle dataValid pulse.
//
//   Every serial half-period is HALF_PERIOD refClock cycles, so a full
//   transaction is 8*2 + 2 + 32*2 = 82 half-periods plus one DONE cycle.
//
// Ports
//   refClock        in   system clock, rising edge
//   nReset          in   asynchronous active-low reset
//   start           in   read request, sampled only while idle
//   channel[7:0]    in   channel index, captured when start is accepted
//   busy            out  transaction in progress
//   dataValid       out  one-cycle pulse when dataOut is updated
//   dataOut[31:0]   out  last word read, held until the next completion
//   clkSelectorData out  address shift clock to the selector
//   inSelectorData  out  address serial data to the selector
//   latchInputData  out  address latch strobe to the selector
//   clkReadData     out  read-back shift clock to the selector
//   serIn           in   serial data from the selector (asynchronous)
// ---------------------------------------------------------------------------
module selector_reader #(
    parameter int HALF_PERIOD = 8
) (
    input  logic        refClock,
    input  logic        nReset,
    input  logic        start,
    input  logic [7:0]  channel,
    output logic        busy,
    output logic        dataValid,
    output logic [31:0] dataOut,
    output logic        clkSelectorData,
    output logic        inSelectorData,
    output logic        latchInputData,
    output logic        clkReadData,
    input  logic        serIn
);

    typedef enum logic [2:0] {IDLE, ADDR, LATCH, READ, DONE} state_t;

    localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

    state_t      r_state;
    logic [7:0]  r_half_cnt;
    logic        r_phase;      // 0 = first half of a bit slot, 1 = second half
    logic [4:0]  r_bit_cnt;
    logic [6:0]  r_addr;       // address bits still to be sent after the current one
    logic [31:0] r_shadow;
    logic [31:0] r_data_out;
    logic        r_busy;
    logic        r_data_valid;
    logic        r_clk_sel;
    logic        r_in_sel;
    logic        r_latch;
    logic        r_clk_rd;
    logic        r_sync1;
    logic        r_sync2;

    logic        w_half_end;

    assign w_half_end = (r_half_cnt == HP_LAST);

    always_ff @(posedge refClock or negedge nReset) begin
        if (!nReset) begin
            r_state      <= IDLE;
            r_half_cnt   <= '0;
            r_phase      <= 1'b0;
            r_bit_cnt    <= '0;
            r_addr       <= '0;
            r_shadow     <= '0;
            r_data_out   <= '0;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_clk_sel    <= 1'b0;
            r_in_sel     <= 1'b0;
            r_latch      <= 1'b0;
            r_clk_rd     <= 1'b0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
        end else begin
            r_sync1      <= serIn;
            r_sync2      <= r_sync1;
            r_data_valid <= 1'b0;

            // The half-period counter only runs in the three serial states.
            if (r_state == ADDR || r_state == LATCH || r_state == READ) begin
                r_half_cnt <= w_half_end ? 8'd0 : r_half_cnt + 8'd1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= ADDR;
                        r_busy    <= 1'b1;
                        r_in_sel  <= channel[7];
                        r_addr    <= channel[6:0];
                        r_clk_sel <= 1'b0;
                        r_half_cnt <= '0;
                        r_phase   <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end

                ADDR: begin
                    if (w_half_end) begin
                        if (!r_phase) begin
                            r_phase   <= 1'b1;
                            r_clk_sel <= 1'b1;
                        end else begin
                            r_phase   <= 1'b0;
                            r_clk_sel <= 1'b0;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= '0;
                                r_in_sel  <= 1'b0;
                                r_latch   <= 1'b1;
                                r_state   <= LATCH;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                                r_in_sel  <= r_addr[6];
                                r_addr    <= {r_addr[5:0], 1'b0};
                            end
                        end
                    end
                end

                LATCH: begin
                    if (w_half_end) begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            r_latch <= 1'b0;
                        end else begin
                            r_phase   <= 1'b0;
                            r_clk_rd  <= 1'b1;
                            r_bit_cnt <= '0;
                            r_state   <= READ;
                        end
                    end
                end

                READ: begin
                    if (w_half_end) begin
                        if (!r_phase) begin
                            // Last cycle of the high phase: take the settled bit.
                            r_phase  <= 1'b1;
                            r_clk_rd <= 1'b0;
                            r_shadow <= {r_shadow[30:0], r_sync2};
                        end else begin
                            r_phase <= 1'b0;
                            if (r_bit_cnt == 5'd31) begin
                                r_bit_cnt <= '0;
                                r_state   <= DONE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                                r_clk_rd  <= 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    r_data_out   <= r_shadow;
                    r_data_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign dataValid       = r_data_valid;
    assign dataOut         = r_data_out;
    assign clkSelectorData = r_clk_sel;
    assign inSelectorData  = r_in_sel;
    assign latchInputData  = r_latch;
    assign clkReadData     = r_clk_rd;

endmodule

// File: tb/tb_selector_reader.sv
// ---------------------------------------------------------------------------
// tb_selector_reader
//   Directed bench for selector_reader. Two instances share one clock:
//   index 0 uses HALF_PERIOD=8, index 1 uses HALF_PERIOD=6. Each instance is
//   attached to a behavioural 256x32 serial selector built from the shared
//   word table mem[].
// ---------------------------------------------------------------------------
module tb_selector_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start;
    logic [1:0]  busy;
    logic [1:0]  dv;
    logic [1:0]  sel_clk;
    logic [1:0]  sel_in;
    logic [1:0]  latch;
    logic [1:0]  rd_clk;
    logic [1:0]  ser_in;
    logic [7:0]  chan [2];
    logic [31:0] dout [2];
    logic [31:0] mem  [256];

    int checks    = 0;
    int errors    = 0;
    int cycle_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int HP = (gi == 0) ? 8 : 6;
        logic [7:0]  m_addr = 8'h00;
        logic [31:0] m_sh   = 32'h0;

        selector_reader #(.HALF_PERIOD(HP)) u_dut (
            .refClock        (clk),
            .nReset          (rst_n),
            .start           (start[gi]),
            .channel         (chan[gi]),
            .busy            (busy[gi]),
            .dataValid       (dv[gi]),
            .dataOut         (dout[gi]),
            .clkSelectorData (sel_clk[gi]),
            .inSelectorData  (sel_in[gi]),
            .latchInputData  (latch[gi]),
            .clkReadData     (rd_clk[gi]),
            .serIn           (ser_in[gi])
        );

        // Selector model: address shifts in MSB first on clk rise, latch loads
        // the addressed word, each read clock fall presents the next bit.
        always @(posedge sel_clk[gi]) m_addr <= {m_addr[6:0], sel_in[gi]};
        always @(posedge latch[gi] or negedge rd_clk[gi]) begin
            if (latch[gi]) m_sh <= mem[m_addr];
            else           m_sh <= {m_sh[30:0], 1'b0};
        end
        assign ser_in[gi] = m_sh[31];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-20s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Waits (bounded) for dataValid of instance k; returns sampled #1 after the edge.
    task automatic wait_dv(input int k);
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (dv[k]) break;
        end
        check("dv_seen", {31'd0, dv[k]}, 32'd1);
    endtask

    task automatic run_txn(input int k, input logic [7:0] c, input logic [31:0] exp_word,
                           input int exp_lat);
        int t0;
        @(negedge clk); start[k] = 1'b1; chan[k] = c;
        @(posedge clk); #1; start[k] = 1'b0; t0 = cycle_cnt;
        check("busy_after_start", {31'd0, busy[k]}, 32'd1);
        wait_dv(k);
        check("latency", 32'(cycle_cnt - t0), 32'(exp_lat));
        check("data_out", dout[k], exp_word);
        check("busy_at_valid", {31'd0, busy[k]}, 32'd0);
        @(posedge clk); #1;
        check("dv_one_cycle", {31'd0, dv[k]}, 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int edges;
        logic prev;
        logic seen;

        rst_n = 1'b0;
        start = 2'b00;
        chan[0] = 8'h00;
        chan[1] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = i[7:0];
            mem[i] = {b, b ^ 8'hFF, b + 8'h11, 8'hC3};
        end
        mem[0]     = 32'h80000001;
        mem[1]     = 32'hAAAAAAAA;
        mem[2]     = 32'h55555555;
        mem[8'h12] = 32'h12121212;
        mem[255]   = 32'hDEADBEEF;

        // Reset state of both instances
        repeat (3) @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_busy",    {31'd0, busy[k]},    32'd0);
            check("rst_dv",      {31'd0, dv[k]},      32'd0);
            check("rst_dout",    dout[k],             32'd0);
            check("rst_sel_clk", {31'd0, sel_clk[k]}, 32'd0);
            check("rst_sel_in",  {31'd0, sel_in[k]},  32'd0);
            check("rst_latch",   {31'd0, latch[k]},   32'd0);
            check("rst_rd_clk",  {31'd0, rd_clk[k]},  32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Channel 0 and channel 255
        run_txn(0, 8'h00, 32'h80000001, 657);
        run_txn(0, 8'hFF, 32'hDEADBEEF, 657);
        check("model_addr_ff", {24'd0, g_dut[0].m_addr}, 32'h000000FF);

        // Start and channel change while busy are ignored
        @(negedge clk); start[0] = 1'b1; chan[0] = 8'h33;
        @(posedge clk); #1; start[0] = 1'b0; t0 = cycle_cnt;
        repeat (100) @(negedge clk);
        start[0] = 1'b1; chan[0] = 8'h12;
        @(negedge clk); start[0] = 1'b0;
        wait_dv(0);
        check("ign_latency", 32'(cycle_cnt - t0), 32'd657);
        check("ign_data_out", dout[0], 32'h33CC44C3);
        check("ign_model_addr", {24'd0, g_dut[0].m_addr}, 32'h00000033);
        repeat (10) @(posedge clk); #1;
        check("ign_no_second", {31'd0, busy[0]}, 32'd0);

        // Reset during READ bit 15 aborts the transaction
        @(negedge clk); start[0] = 1'b1; chan[0] = 8'h77;
        @(posedge clk); #1; start[0] = 1'b0;
        edges = 0;
        prev  = 1'b0;
        for (int n = 0; n < 3000 && edges < 16; n++) begin
            @(posedge clk); #1;
            if (rd_clk[0] && !prev) edges++;
            prev = rd_clk[0];
        end
        check("rd_edges", 32'(edges), 32'd16);
        repeat (3) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check("abort_busy",    {31'd0, busy[0]},    32'd0);
        check("abort_dv",      {31'd0, dv[0]},      32'd0);
        check("abort_dout",    dout[0],             32'd0);
        check("abort_rd_clk",  {31'd0, rd_clk[0]},  32'd0);
        check("abort_latch",   {31'd0, latch[0]},   32'd0);
        check("abort_sel_clk", {31'd0, sel_clk[0]}, 32'd0);
        check("abort_sel_in",  {31'd0, sel_in[0]},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (dv[0] || busy[0]) seen = 1'b1;
        end
        check("abort_quiet", {31'd0, seen}, 32'd0);
        run_txn(0, 8'h5A, 32'h5AA56BC3, 657);

        // Back-to-back with start held high
        @(negedge clk); start[0] = 1'b1; chan[0] = 8'h40;
        @(posedge clk); #1; t0 = cycle_cnt;
        wait_dv(0); t1 = cycle_cnt;
        check("b2b_latency1", 32'(t1 - t0), 32'd657);
        check("b2b_data1", dout[0], 32'h40BF51C3);
        check("b2b_idle_gap", {31'd0, busy[0]}, 32'd0);
        @(posedge clk); #1;
        check("b2b_dv_width", {31'd0, dv[0]}, 32'd0);
        check("b2b_restart", {31'd0, busy[0]}, 32'd1);
        wait_dv(0);
        check("b2b_spacing", 32'(cycle_cnt - t1), 32'd658);
        check("b2b_data2", dout[0], 32'h40BF51C3);
        @(negedge clk); start[0] = 1'b0;
        @(posedge clk); #1;
        check("b2b_dv_width2", {31'd0, dv[0]}, 32'd0);
        check("b2b_stop", {31'd0, busy[0]}, 32'd0);

        // HALF_PERIOD=6 instance, alternating patterns
        run_txn(1, 8'h01, 32'hAAAAAAAA, 493);
        run_txn(1, 8'h02, 32'h55555555, 493);
        run_txn(1, 8'h01, 32'hAAAAAAAA, 493);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
